rr_sel_arb3: RTL
================

RR_SEL_ARB3 -- requirements
Module: rr_sel_arb3

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum number of consecutive grant cycles per owner (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port req, input, 3 bits: request lines; req[k] requests routing of mux input ik.
REQ-005 The block SHALL have port done, input, 1 bit: the current owner releases the mux at the next edge.
REQ-006 The block SHALL have port sel, output, 2 bits: select for the downstream 3:1 mux (00=i0, 01=i1, 10=i2).
REQ-007 The block SHALL have port grant, output, 3 bits: one-hot owner indication, or 000 when idle.
REQ-008 The block SHALL have port busy, output, 1 bit: high while any grant is active.
REQ-009 The block SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release at MAX_HOLD.

Function
REQ-010 All outputs SHALL be registered; no combinational path SHALL exist from req or done to any output.
REQ-011 The block SHALL implement two states: IDLE (grant=000, busy=0) and OWN (grant one-hot, busy=1).
REQ-012 In IDLE, when req!=000 at an edge, the block SHALL enter OWN at that edge, so grant appears 1 cycle after req is sampled.
REQ-013 Owner selection SHALL be round-robin: the search starts at index (last+1) mod 3 and takes the first set req bit; last is the most recent owner (reset value 2).
REQ-014 sel SHALL equal the binary index of the owner while in OWN.
REQ-015 In IDLE, sel SHALL hold its last value; sel SHALL never be 2'b11.
REQ-016 A 2-bit pointer last SHALL update to the new owner on every grant.
REQ-017 In OWN, a hold counter SHALL count grant cycles; it SHALL be 0 in the first grant cycle and increment each cycle the owner is kept.
REQ-018 The owner SHALL be released at an edge when any of these holds: done=1; req[owner]=0; or hold counter = MAX_HOLD-1.
REQ-019 If the release is caused only by the hold counter (done=1 and req[owner]=0 not true), timeout SHALL be 1 for the cycle after that edge and 0 otherwise.
REQ-020 On release, if any req bit other than the owner's is set, the next owner SHALL be granted at the same edge, with zero dead cycles and the counter reset to 0.
REQ-021 On release, if only the owner's req bit is still set, the owner SHALL be re-granted with the counter reset to 0; timeout SHALL still pulse if the release was forced.
REQ-022 On release with no eligible req, the block SHALL return to IDLE.
REQ-023 done SHALL be ignored in IDLE.
REQ-024 done and timeout coinciding at the same edge SHALL be treated as a done release, with no timeout pulse.
REQ-025 grant SHALL always be one-hot or zero; busy SHALL equal the OR of the grant bits.
REQ-026 The hold counter width SHALL be 8 bits; the counter SHALL never wrap, because release occurs at MAX_HOLD-1.

Reset
REQ-027 While rst_n=0 at an edge, the block SHALL set: state IDLE, grant=000, busy=0, timeout=0, sel=00, last=2, counter=0.
REQ-028 Reset asserted mid-grant SHALL drop grant at that same edge, regardless of req or done.
REQ-029 After rst_n returns high, the first grant SHALL go to the lowest set req index (search starts at 0).

Verification (MAX_HOLD=4)
REQ-030 Reset release, then req=010 held: grant=010, sel=01, busy=1 one cycle later.
REQ-031 req=111 held, done pulsed every 2nd grant cycle: owners cycle i0,i1,i2,i0 with sel 00,01,10,00 and no idle cycle between owners.
REQ-032 req=001 held, done=0: grant=001 for exactly 4 cycles, timeout=1 for one cycle, then i0 is re-granted with sel unchanged.
REQ-033 req=011 held, done=0, i0 owning: after 4 cycles i1 is granted at the release edge and timeout pulses once.
REQ-034 rst_n=0 for one cycle while grant=100: at the next edge grant=000, sel=00, busy=0; after release, req=111 grants i0.
REQ-035 The bench SHALL check every cycle that grant is one-hot or zero, that sel is never 11, and that busy equals the OR of grant.

Source files
------------

// File: rtl/rr_sel_arb3.sv
// rr_sel_arb3 -- round-robin owner arbiter driving the select of a 3:1 mux.
//
// Three requesters compete for one downstream 3:1 mux. An owner keeps the
// mux until it asserts done, drops its request, or has held the mux for
// MAX_HOLD cycles. When the hold limit forces the release, timeout pulses for
// one cycle. At a release the next owner is chosen at the same edge, so there
// are no dead cycles. Every output comes straight from a flop.
//
// Ports:
//   clk     in   1  clock, rising edge
//   rst_n   in   1  synchronous active-low reset
//   req     in   3  request lines, req[k] asks for mux input ik
//   done    in   1  current owner gives up the mux at the next edge
//   sel     out  2  mux select (00=i0, 01=i1, 10=i2), held while idle
//   grant   out  3  one-hot owner, 000 when idle
//   busy    out  1  OR of grant
//   timeout out  1  one-cycle pulse after a release forced by the hold limit
module rr_sel_arb3 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic [2:0] grant,
  output logic       busy,
  output logic       timeout
);

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] last_reg, last_next;
  logic [7:0] hold_reg, hold_next;
  logic [1:0] sel_reg, sel_next;
  logic [2:0] grant_reg, grant_next;
  logic       busy_reg, busy_next;
  logic       timeout_reg, timeout_next;

  // Candidate order for the round-robin search: offsets 1, 2, 3 from the
  // previous owner, i.e. the two other requesters first and the previous
  // owner itself last.
  logic [1:0] cand_idx [3];
  logic [2:0] cand_hit;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cand
      localparam logic [2:0] OFFSET = 3'(gi + 1);
      logic [2:0] cand_sum;
      assign cand_sum      = {1'b0, last_reg} + OFFSET;
      assign cand_idx[gi]  = (cand_sum >= 3'd3) ? 2'(cand_sum - 3'd3) : cand_sum[1:0];
      assign cand_hit[gi]  = req[cand_idx[gi]];
    end
  endgenerate

  logic       pick_valid;
  logic [1:0] pick_idx;

  always_comb begin
    pick_valid = |cand_hit;
    pick_idx   = cand_idx[2];
    if (cand_hit[1]) pick_idx = cand_idx[1];
    if (cand_hit[0]) pick_idx = cand_idx[0];
  end

  // In OWN the owner is always last_reg, since last updates on every grant.
  logic owner_req;
  logic hold_max;
  logic release_evt;
  logic forced_release;

  assign owner_req      = req[last_reg];
  assign hold_max       = (hold_reg == HOLD_LAST);
  assign release_evt    = done | ~owner_req | hold_max;
  assign forced_release = hold_max & ~done & owner_req;

  // State register (also holds the registered outputs).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      last_reg    <= 2'd2;
      hold_reg    <= 8'd0;
      sel_reg     <= 2'd0;
      grant_reg   <= 3'b000;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      hold_reg    <= hold_next;
      sel_reg     <= sel_next;
      grant_reg   <= grant_next;
      busy_reg    <= busy_next;
      timeout_reg <= timeout_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    hold_next  = hold_reg;
    case (state_reg)
      S_IDLE: begin
        // done carries no meaning without an owner.
        if (pick_valid) begin
          state_next = S_OWN;
          last_next  = pick_idx;
          hold_next  = 8'd0;
        end
      end
      S_OWN: begin
        if (release_evt) begin
          hold_next = 8'd0;
          if (pick_valid) begin
            // Hand over (or re-grant) at the same edge.
            last_next = pick_idx;
          end else begin
            state_next = S_IDLE;
          end
        end else begin
          hold_next = hold_reg + 8'd1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Output logic: values the output flops take at the next edge.
  generate
    for (gi = 0; gi < 3; gi++) begin : g_grant
      localparam logic [1:0] IDX = 2'(gi);
      assign grant_next[gi] = (state_next == S_OWN) && (last_next == IDX);
    end
  endgenerate

  always_comb begin
    sel_next     = sel_reg;
    busy_next    = (state_next == S_OWN);
    timeout_next = (state_reg == S_OWN) && forced_release;
    if (state_next == S_OWN) sel_next = last_next;
  end

  assign sel     = sel_reg;
  assign grant   = grant_reg;
  assign busy    = busy_reg;
  assign timeout = timeout_reg;

endmodule
